// File: rtl/sar_pkg.sv
// ============================================================================
// sar_pkg: shared types and constants for the sar_search controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sar_pkg;

  localparam int SAR_WIDTH = 16;
  localparam int SAR_IDX_W = $clog2(SAR_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIAL = 2'd1,
    ST_DONE  = 2'd2
  } sar_state_e;

endpackage

`default_nettype wire

// File: rtl/sar_search.sv
// ============================================================================
// sar_search: successive-approximation search against an external comparator.
// Optional macro SAR_FLAG_CHECK_EN aborts a search on an illegal gt/lt/eq set.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             early,
  output logic             err
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(WIDTH - 1);

  sar_state_e       state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [IDXW-1:0]  idx, idx_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             early_q, early_n;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] trial_word;
  logic [WIDTH-1:0] acc_upd;

  assign mask       = WIDTH'(1) << idx;
  assign trial_word = acc | mask;
  // gt keeps the bit cleared; lt and the all-low case both keep it set.
  assign acc_upd    = gt ? acc : trial_word;

`ifdef SAR_FLAG_CHECK_EN
  logic err_q, err_n;
  logic flag_bad;
  assign flag_bad = ~((gt ^ lt ^ eq) & ~(gt & lt & eq));
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      idx      <= IDX_MAX;
      result_q <= '0;
      early_q  <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      idx      <= idx_n;
      result_q <= result_n;
      early_q  <= early_n;
    end
  end

`ifdef SAR_FLAG_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_n;
    end
  end
`endif

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    idx_n    = idx;
    result_n = result_q;
    early_n  = early_q;
`ifdef SAR_FLAG_CHECK_EN
    err_n    = err_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_TRIAL;
          acc_n   = '0;
          idx_n   = IDX_MAX;
          early_n = 1'b0;
`ifdef SAR_FLAG_CHECK_EN
          err_n   = 1'b0;
`endif
        end
      end
      ST_TRIAL: begin
`ifdef SAR_FLAG_CHECK_EN
        if (flag_bad) begin
          err_n    = 1'b1;
          result_n = acc;
          state_n  = ST_DONE;
        end else
`endif
        if (eq) begin
          result_n = trial_word;
          early_n  = 1'b1;
          state_n  = ST_DONE;
        end else begin
          acc_n = acc_upd;
          if (idx == '0) begin
            result_n = acc_upd;
            state_n  = ST_DONE;
          end else begin
            idx_n = idx - IDXW'(1);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign probe  = (state == ST_TRIAL) ? trial_word : '0;
  assign busy   = (state == ST_TRIAL);
  assign done   = (state == ST_DONE);
  assign result = result_q;
  assign early  = early_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// Bench for sar_search: a comparator model answers each probe; expected
// results go into a scoreboard at start and are checked when done pulses.
`timescale 1ns/1ps
`default_nettype none

module tb_sar_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] probe;
  logic [15:0] target;
  logic        ovr;
  logic        gt, lt, eq;
  logic        busy, done, early, err;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Comparator model; ovr forces the illegal gt=lt=1 combination.
  assign gt = ovr | (probe > target);
  assign lt = ovr | (probe < target);
  assign eq = ~ovr & (probe == target);

  sar_search #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe),
    .gt(gt), .lt(lt), .eq(eq), .busy(busy), .done(done),
    .result(result), .early(early), .err(err)
  );

  typedef struct {
    logic [15:0] tgt;
    int          inj;
    logic [15:0] res;
    logic        ee;
    logic        eerr;
    int          lat;
    bit          hold;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ee;
    logic        eerr;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_probe"}, 32'(probe), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_result"}, 32'(result), 32'h0);
    check({tag, "_early"}, 32'(early), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic run(input vec_t v, input bit chk_probe);
    exp_t        e;
    exp_t        got;
    int          c;
    int          trial;
    bit          seen;
    logic [31:0] one;
    logic [15:0] pexp;
    target = v.tgt;
    e.res  = v.res;
    e.ee   = v.ee;
    e.eerr = v.eerr;
    e.lat  = v.lat;
    sbq.push_back(e);
    check("idle_probe", 32'(probe), 32'h0);
    start = 1'b1;
    tick();
    if (!v.hold) start = 1'b0;
    c = 1;
    trial = 0;
    seen = 1'b0;
    one = 32'h1;
    while (!seen && c <= 40) begin
      if (busy) begin
        trial++;
        ovr = (trial == v.inj);
        if (chk_probe) begin
          pexp = 16'(one << (16 - trial));
          check("probe_seq", 32'(probe), 32'(pexp));
        end
      end else begin
        ovr = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
        got = sbq.pop_front();
        check("result", 32'(result), 32'(got.res));
        check("early", 32'(early), 32'(got.ee));
        check("err", 32'(err), 32'(got.eerr));
        check("latency", 32'(c), 32'(got.lat));
        check("done_probe", 32'(probe), 32'h0);
        check("done_busy", 32'(busy), 32'h0);
      end else begin
        tick();
        c++;
      end
    end
    ovr = 1'b0;
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within 40 cycles for target %h", v.tgt);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    tick();
    check("done_pulse", 32'(done), 32'h0);
    check("idle_after", 32'(busy), 32'h0);
    check("result_hold", 32'(result), 32'(v.res));
  endtask

  initial begin
    int trial;
    rst = 1'b1;
    start = 1'b0;
    target = 16'h0;
    ovr = 1'b0;

    //            tgt     inj  res      ee    eerr  lat  hold
    vecs[0] = '{16'h0000, 0, 16'h0000, 1'b0, 1'b0, 17, 1'b0};
    vecs[1] = '{16'hA5C3, 0, 16'hA5C3, 1'b1, 1'b0, 17, 1'b0};
    vecs[2] = '{16'h8000, 0, 16'h8000, 1'b1, 1'b0,  2, 1'b0};
    vecs[3] = '{16'hFFFF, 0, 16'hFFFF, 1'b1, 1'b0, 17, 1'b1};
    vecs[4] = '{16'hFFFF, 0, 16'hFFFF, 1'b1, 1'b0, 17, 1'b0};
    vecs[5] = '{16'h4000, 0, 16'h4000, 1'b1, 1'b0,  3, 1'b0};
    vecs[6] = '{16'hFFFE, 0, 16'hFFFE, 1'b1, 1'b0, 16, 1'b0};
    vecs[7] = '{16'h0001, 0, 16'h0001, 1'b1, 1'b0, 17, 1'b0};
`ifdef SAR_FLAG_CHECK_EN
    vecs[8] = '{16'hF000, 3, 16'hC000, 1'b0, 1'b1,  4, 1'b0};
`else
    vecs[8] = '{16'hF000, 3, 16'hDFFF, 1'b0, 1'b0, 17, 1'b0};
`endif
    vecs[9] = '{16'hA5C2, 0, 16'hA5C2, 1'b1, 1'b0, 16, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      run(vecs[i], vecs[i].tgt == 16'h0000);
    end

    // Reset during trial 5 of a search, then a fresh search.
    target = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    trial = 0;
    for (int k = 0; k < 20 && trial < 5; k++) begin
      if (busy) trial++;
      if (trial < 5) tick();
    end
    check("midrst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    run('{16'h0042, 0, 16'h0042, 1'b1, 1'b0, 16, 1'b0}, 1'b0);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
